// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the MEM-stage data-memory access controller.
// Holds the RV32I load/store FUNC3 encodings, the controller state encoding
// and small decode helpers shared by the controller and its load extender.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Request is illegal when both strobes are high or FUNC3 is not a valid
  // encoding for the requested direction.
  function automatic logic req_illegal_f(input logic rd, input logic wr,
                                         input logic [2:0] f3);
    logic ill;
    ill = 1'b0;
    if (rd && wr) begin
      ill = 1'b1;
    end else if (rd) begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ill = 1'b0;
        default:                        ill = 1'b1;
      endcase
    end else if (wr) begin
      case (f3)
        F3_B, F3_H, F3_W: ill = 1'b0;
        default:          ill = 1'b1;
      endcase
    end else begin
      ill = 1'b0;
    end
    return ill;
  endfunction

  // Access size comes from FUNC3[1:0]: 00 byte, 01 halfword, 10 word.
  function automatic logic misaligned_f(input logic [1:0] size,
                                        input logic [1:0] off);
    logic mis;
    case (size)
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a memory word and
// sign- or zero-extends it according to the load FUNC3.
// Ports:
//   word   - 32-bit word read from data memory
//   offset - byte offset within the word captured at request time
//   func3  - RV32I load encoding (LB/LH/LW/LBU/LHU)
//   result - extended 32-bit load value
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = word;
    case (offset)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (func3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_BU:   result = {24'h000000, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_HU:   result = {16'h0000, half_s};
      F3_W:    result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory access controller. Converts a
// load/store request into a word-addressed memory access with byte enables,
// handshakes on the memory busywait, stalls the pipeline until the access
// completes and returns the extended load result.
// Ports:
//   CLK, RESET                 - clock (rising edge), async active-low reset
//   MEM_READ, MEM_WRITE, FUNC3 - request and size/sign from EX/MEM
//   ALU_OUT, STORE_DATA        - byte address and forwarded store data
//   BUSYWAIT                   - pipeline stall request (combinational)
//   LOAD_DATA, MEM_FAULT       - registered load result and fault pulse
//   DMEM_*                     - registered memory interface, plus the
//                                memory's read word and busywait inputs
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ALU_OUT,
  input  logic [31:0] STORE_DATA,
  output logic        BUSYWAIT,
  output logic [31:0] LOAD_DATA,
  output logic        MEM_FAULT,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [29:0] DMEM_ADDR,
  output logic [31:0] DMEM_WRITEDATA,
  output logic [3:0]  DMEM_BYTE_EN,
  input  logic [31:0] DMEM_READDATA,
  input  logic        DMEM_BUSYWAIT
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_t               state_r;
  logic [TIMEOUT_W-1:0] cnt_r;
  logic [TIMEOUT_W-1:0] cnt_inc_s;
  logic [1:0]           off_r;
  logic [2:0]           func3_r;
  logic                 is_load_r;

  logic        req_s;
  logic        bad_s;
  logic        valid_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] ext_s;

  // Request decode: legality, alignment, byte enables and lane-replicated data.
  always_comb begin
    req_s   = MEM_READ ^ MEM_WRITE;
    bad_s   = (MEM_READ | MEM_WRITE) &
              (req_illegal_f(MEM_READ, MEM_WRITE, FUNC3) |
               misaligned_f(FUNC3[1:0], ALU_OUT[1:0]));
    valid_s = req_s & ~bad_s;
    if (MEM_WRITE) begin
      case (FUNC3[1:0])
        2'b00:   be_s = 4'b0001 << ALU_OUT[1:0];
        2'b01:   be_s = 4'b0011 << {ALU_OUT[1], 1'b0};
        default: be_s = 4'b1111;
      endcase
    end else begin
      be_s = 4'b1111;
    end
    case (FUNC3[1:0])
      2'b00:   wdata_s = {4{STORE_DATA[7:0]}};
      2'b01:   wdata_s = {2{STORE_DATA[15:0]}};
      default: wdata_s = STORE_DATA;
    endcase
    cnt_inc_s = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  end

  // Stall: starting a valid access and the whole ACCESS phase; held low in reset.
  always_comb begin
    if (!RESET) begin
      BUSYWAIT = 1'b0;
    end else if (state_r == ACCESS) begin
      BUSYWAIT = 1'b1;
    end else if (state_r == IDLE) begin
      BUSYWAIT = valid_s;
    end else begin
      BUSYWAIT = 1'b0;
    end
  end

  load_extend u_load_extend (
    .word   (DMEM_READDATA),
    .offset (off_r),
    .func3  (func3_r),
    .result (ext_s)
  );

  // Access FSM with registered memory strobes, load result and fault pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      off_r          <= 2'b00;
      func3_r        <= 3'b000;
      is_load_r      <= 1'b0;
      DMEM_READ      <= 1'b0;
      DMEM_WRITE     <= 1'b0;
      DMEM_ADDR      <= 30'h0;
      DMEM_WRITEDATA <= 32'h0;
      DMEM_BYTE_EN   <= 4'h0;
      LOAD_DATA      <= 32'h0;
      MEM_FAULT      <= 1'b0;
    end else begin
      MEM_FAULT <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_s) begin
            DMEM_ADDR      <= ALU_OUT[31:2];
            DMEM_BYTE_EN   <= be_s;
            DMEM_WRITEDATA <= wdata_s;
            DMEM_READ      <= MEM_READ;
            DMEM_WRITE     <= MEM_WRITE;
            off_r          <= ALU_OUT[1:0];
            func3_r        <= FUNC3;
            is_load_r      <= MEM_READ;
            cnt_r          <= '0;
            state_r        <= ACCESS;
          end else if (bad_s) begin
            MEM_FAULT <= 1'b1;
          end
        end
        ACCESS: begin
          if (!DMEM_BUSYWAIT) begin
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            if (is_load_r) begin
              LOAD_DATA <= ext_s;
            end
            state_r <= DONE;
          end else if (cnt_inc_s == TIMEOUT_LIM) begin
            // Memory never answered: abandon the access and report it.
            cnt_r      <= cnt_inc_s;
            DMEM_READ  <= 1'b0;
            DMEM_WRITE <= 1'b0;
            LOAD_DATA  <= 32'h0;
            MEM_FAULT  <= 1'b1;
            state_r    <= DONE;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        DONE: begin
          // Pipeline advances this cycle; the stale request is ignored.
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: self-checking bench for dmem_access_ctrl. A behavioural
// model of the access protocol predicts every output each cycle; directed
// sequences add literal expectations, then randomized traffic follows.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        CLK;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNC3;
  logic [31:0] ALU_OUT;
  logic [31:0] STORE_DATA;
  logic        BUSYWAIT;
  logic [31:0] LOAD_DATA;
  logic        MEM_FAULT;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [29:0] DMEM_ADDR;
  logic [31:0] DMEM_WRITEDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_BUSYWAIT;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .FUNC3          (FUNC3),
    .ALU_OUT        (ALU_OUT),
    .STORE_DATA     (STORE_DATA),
    .BUSYWAIT       (BUSYWAIT),
    .LOAD_DATA      (LOAD_DATA),
    .MEM_FAULT      (MEM_FAULT),
    .DMEM_READ      (DMEM_READ),
    .DMEM_WRITE     (DMEM_WRITE),
    .DMEM_ADDR      (DMEM_ADDR),
    .DMEM_WRITEDATA (DMEM_WRITEDATA),
    .DMEM_BYTE_EN   (DMEM_BYTE_EN),
    .DMEM_READDATA  (DMEM_READDATA),
    .DMEM_BUSYWAIT  (DMEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic last_bw;
  int   bw_count;

  // Model: an access in flight, the one-cycle release after it, wait count.
  bit          m_busy, m_tail, m_load;
  int          m_waits, m_off, m_f3;
  logic        e_rd, e_wr, e_fault;
  logic [29:0] e_addr;
  logic [31:0] e_wd, e_ld;
  logic [3:0]  e_be;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  function automatic bit m_bad(input bit rd, input bit wr, input int f3, input logic [31:0] alu);
    int sz;
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (rd && !(f3 inside {0, 1, 2, 4, 5})) return 1'b1;
    if (wr && !(f3 inside {0, 1, 2})) return 1'b1;
    sz = 1 << (f3 % 4);
    return (alu % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(input bit wr, input int f3, input logic [31:0] alu);
    int sz;
    if (!wr) return 4'hF;
    sz = 1 << (f3 % 4);
    return 4'(((1 << sz) - 1) << (alu % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] sd);
    int sz;
    logic [31:0] b, h;
    sz = 1 << (f3 % 4);
    b = sd & 32'h000000FF;
    h = sd & 32'h0000FFFF;
    if (sz == 1) return b * 32'h01010101;
    if (sz == 2) return h * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_extend(input logic [31:0] word, input int off, input int f3);
    int sz, bits;
    logic [63:0] m;
    logic [31:0] v;
    sz = 1 << (f3 % 4);
    if (sz == 4) return word;
    bits = 8 * sz;
    m = (64'd1 << bits) - 64'd1;
    v = (word >> (8 * off)) & m[31:0];
    if (f3 < 4 && ((v >> (bits - 1)) & 32'd1) == 32'd1) v = v | ~m[31:0];
    return v;
  endfunction

  function automatic logic m_busywait();
    if (!RESET) return 1'b0;
    if (m_busy) return 1'b1;
    if (m_tail) return 1'b0;
    return (MEM_READ ^ MEM_WRITE) && !m_bad(MEM_READ, MEM_WRITE, FUNC3, ALU_OUT);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_tail = 0; m_load = 0; m_waits = 0; m_off = 0; m_f3 = 0;
    e_rd = 0; e_wr = 0; e_fault = 0; e_addr = '0; e_wd = '0; e_ld = '0; e_be = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    e_fault = 1'b0;
    if (m_busy) begin
      if (!DMEM_BUSYWAIT) begin
        e_rd = 0; e_wr = 0;
        if (m_load) e_ld = m_extend(DMEM_READDATA, m_off, m_f3);
        m_busy = 0; m_tail = 1;
      end else begin
        m_waits++;
        if (m_waits >= TO) begin
          e_rd = 0; e_wr = 0; e_fault = 1; e_ld = '0;
          m_busy = 0; m_tail = 1;
        end
      end
    end else if (m_tail) begin
      m_tail = 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (m_bad(MEM_READ, MEM_WRITE, FUNC3, ALU_OUT)) begin
        e_fault = 1'b1;
      end else begin
        e_addr = ALU_OUT >> 2;
        e_be   = m_be(MEM_WRITE, FUNC3, ALU_OUT);
        e_wd   = m_wdata(FUNC3, STORE_DATA);
        e_rd   = MEM_READ;
        e_wr   = MEM_WRITE;
        m_busy = 1; m_waits = 0;
        m_off  = ALU_OUT % 4; m_f3 = FUNC3; m_load = MEM_READ;
      end
    end
  endtask

  task automatic check_outputs();
    check("dmem_read", DMEM_READ, e_rd);
    check("dmem_write", DMEM_WRITE, e_wr);
    check("mem_fault", MEM_FAULT, e_fault);
    check("dmem_addr", DMEM_ADDR, e_addr);
    check("byte_en", DMEM_BYTE_EN, e_be);
    check("load_data", LOAD_DATA, e_ld);
    if (e_wr) check("writedata", DMEM_WRITEDATA, e_wd);
  endtask

  // Called just after a falling edge: drive, check stall, clock, check outputs.
  task automatic do_cycle(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input logic [31:0] rdata, input logic dbusy);
    MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ALU_OUT = alu;
    STORE_DATA = sd; DMEM_READDATA = rdata; DMEM_BUSYWAIT = dbusy;
    #1;
    last_bw = BUSYWAIT;
    check("busywait", BUSYWAIT, m_busywait());
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int r, sz;
    logic [2:0] f3;
    logic [31:0] alu;
    logic rd, wr;

    model_reset();
    RESET = 1'b0;
    MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNC3 = 3'b010; ALU_OUT = 32'h0;
    STORE_DATA = 32'h0; DMEM_READDATA = 32'h0; DMEM_BUSYWAIT = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busywait", BUSYWAIT, 32'h0);
    check("rst_dmem_read", DMEM_READ, 32'h0);
    check("rst_load_data", LOAD_DATA, 32'h0);
    check("rst_byte_en", DMEM_BYTE_EN, 32'h0);
    MEM_READ = 1'b0;
    RESET = 1'b1;

    // SW 0x100, zero-wait memory.
    do_cycle(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    check("sw_bw_c1", last_bw, 32'h1);
    check("sw_write", DMEM_WRITE, 32'h1);
    check("sw_addr", DMEM_ADDR, 32'h40);
    check("sw_be", DMEM_BYTE_EN, 32'hF);
    check("sw_wdata", DMEM_WRITEDATA, 32'hDEADBEEF);
    do_cycle(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    check("sw_bw_c2", last_bw, 32'h1);
    check("sw_write_drop", DMEM_WRITE, 32'h0);
    do_cycle(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    check("sw_bw_done", last_bw, 32'h0);
    check("sw_done_ignored", DMEM_WRITE, 32'h0);
    idle_cycle();

    // LB then LBU at 0x103.
    do_cycle(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 1'b0);
    check("lb_read", DMEM_READ, 32'h1);
    check("lb_be", DMEM_BYTE_EN, 32'hF);
    do_cycle(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1'b0);
    check("lb_data", LOAD_DATA, 32'hFFFFFF80);
    idle_cycle();
    do_cycle(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h0, 1'b0);
    do_cycle(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1'b0);
    check("lbu_data", LOAD_DATA, 32'h00000080);
    idle_cycle();

    // SH 0x202 with three memory wait cycles.
    bw_count = 0;
    do_cycle(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b0);
    bw_count += int'(last_bw);
    check("sh_be", DMEM_BYTE_EN, 32'hC);
    check("sh_wdata", DMEM_WRITEDATA, 32'hABCDABCD);
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b1);
      bw_count += int'(last_bw);
      check("sh_write_held", DMEM_WRITE, 32'h1);
    end
    do_cycle(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1'b0);
    bw_count += int'(last_bw);
    check("sh_write_drop", DMEM_WRITE, 32'h0);
    idle_cycle();
    bw_count += int'(last_bw);
    check("sh_stall_cycles", bw_count, 32'd5);

    // Misaligned LW and both strobes high.
    do_cycle(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b0);
    check("mis_bw", last_bw, 32'h0);
    check("mis_fault", MEM_FAULT, 32'h1);
    check("mis_no_read", DMEM_READ, 32'h0);
    idle_cycle();
    check("mis_fault_pulse", MEM_FAULT, 32'h0);
    do_cycle(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0);
    check("both_bw", last_bw, 32'h0);
    check("both_fault", MEM_FAULT, 32'h1);
    idle_cycle();

    // Timeout with memory stuck busy.
    do_cycle(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      do_cycle(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h55555555, 1'b1);
      check("to_read", DMEM_READ, (k < TO) ? 32'h1 : 32'h0);
      check("to_fault", MEM_FAULT, (k < TO) ? 32'h0 : 32'h1);
    end
    check("to_load_zero", LOAD_DATA, 32'h0);
    idle_cycle();
    check("to_done_bw", last_bw, 32'h0);
    idle_cycle();

    // Reset in the middle of an access.
    do_cycle(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b0);
    do_cycle(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1);
    check("mid_read", DMEM_READ, 32'h1);
    RESET = 1'b0;
    #1;
    check("mid_rst_read", DMEM_READ, 32'h0);
    check("mid_rst_bw", BUSYWAIT, 32'h0);
    model_reset();
    @(negedge CLK);
    MEM_READ = 1'b0;
    RESET = 1'b1;
    do_cycle(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b0);
    do_cycle(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 1'b0);
    check("post_rst_lw", LOAD_DATA, 32'h12345678);
    idle_cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      rd = (r >= 4 && r <= 6) || r == 9;
      wr = (r >= 7);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        r = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end
      alu = $urandom;
      sz = 1 << (f3 % 4);
      if ($urandom_range(0, 3) != 0) alu = alu & ~(32'(sz) - 32'd1);
      do_cycle(rd, wr, f3, alu, $urandom, $urandom, $urandom_range(0, 99) < 55);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
